// File: rtl/life_pkg.sv
// Shared types and grid geometry for the Life generation scheduler.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SWEEP     = 2'd1,
        DRAIN     = 2'd2,
        PEND_SWAP = 2'd3
    } sched_state_t;

    localparam int unsigned GRID_W = 40;
    localparam int unsigned GRID_H = 30;
    localparam int unsigned XW     = $clog2(GRID_W);
    localparam int unsigned YW     = $clog2(GRID_H);

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x,y) cell counter; wraps to (0,0) after the last cell.
module raster_counter #(
    parameter int unsigned WIDTH  = 40,
    parameter int unsigned HEIGHT = 30
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      inc,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic                      last
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);

    logic x_end;
    logic y_end;

    assign x_end = (x == XW'(WIDTH - 1));
    assign y_end = (y == YW'(HEIGHT - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/life_gen_scheduler.sv
// Sequences one Life generation: issues cells, writes results to the back bank,
// swaps banks at frame start. Optional auto-start: LIFE_SCHED_AUTO_STEP_EN.
module life_gen_scheduler
    import life_pkg::*;
#(
    parameter int unsigned WIDTH          = GRID_W,
    parameter int unsigned HEIGHT         = GRID_H,
    parameter int unsigned GEN_W          = 16,
    parameter int unsigned FRAMES_PER_GEN = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      step,
    input  logic                      frame_start,
    output logic                      eng_valid,
    input  logic                      eng_ready,
    output logic [$clog2(WIDTH)-1:0]  eng_x,
    output logic [$clog2(HEIGHT)-1:0] eng_y,
    input  logic                      res_valid,
    input  logic                      res_data,
    output logic                      wr_en,
    output logic [$clog2(WIDTH)-1:0]  wr_x,
    output logic [$clog2(HEIGHT)-1:0] wr_y,
    output logic                      wr_data,
    output logic                      disp_bank,
    output logic                      busy,
    output logic [GEN_W-1:0]          gen_count
);

    sched_state_t state;
    sched_state_t state_next;

    logic start_c;
    logic auto_start_c;
    logic issue_fire;
    logic issue_last;
    logic wr_last;
    logic swap_c;
    logic eng_valid_d;
    logic busy_d;

    assign issue_fire = eng_valid && eng_ready && (state == SWEEP);
    assign start_c    = (state == IDLE) && enable && (step || auto_start_c);

`ifdef LIFE_SCHED_AUTO_STEP_EN
    localparam int unsigned FCW = $clog2(FRAMES_PER_GEN + 1);

    logic [FCW-1:0] frame_cnt;

    // Counts frames spent idle while enabled; the last one starts a generation.
    assign auto_start_c = (state == IDLE) && enable && frame_start &&
                          (frame_cnt == FCW'(FRAMES_PER_GEN - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (!enable || start_c) begin
            frame_cnt <= '0;
        end else if ((state == IDLE) && frame_start) begin
            frame_cnt <= frame_cnt + FCW'(1);
        end
    end
`else
    logic unused_frames_per_gen;

    assign auto_start_c          = 1'b0;
    assign unused_frames_per_gen = ^32'(FRAMES_PER_GEN);
`endif

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_issue_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_c),
        .inc     (issue_fire),
        .x       (eng_x),
        .y       (eng_y),
        .last    (issue_last)
    );

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_write_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_c),
        .inc     (wr_en),
        .x       (wr_x),
        .y       (wr_y),
        .last    (wr_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The final issue and final write may coincide with a zero-latency engine.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_c) state_next = SWEEP;
            end
            SWEEP: begin
                if (issue_fire && issue_last) begin
                    state_next = (wr_en && wr_last) ? PEND_SWAP : DRAIN;
                end
            end
            DRAIN: begin
                if (wr_en && wr_last) state_next = PEND_SWAP;
            end
            PEND_SWAP: begin
                if (frame_start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_data     = 1'b0;
        swap_c      = 1'b0;
        eng_valid_d = 1'b0;
        busy_d      = 1'b0;
        wr_en       = res_valid && ((state == SWEEP) || (state == DRAIN));
        wr_data     = wr_en && res_data;
        swap_c      = (state == PEND_SWAP) && frame_start;
        eng_valid_d = (state_next == SWEEP) && enable;
        busy_d      = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_valid <= 1'b0;
            busy      <= 1'b0;
            disp_bank <= 1'b0;
            gen_count <= '0;
        end else begin
            eng_valid <= eng_valid_d;
            busy      <= busy_d;
            if (swap_c) begin
                disp_bank <= ~disp_bank;
                gen_count <= gen_count + GEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler with a 3-cycle echo engine model.
module tb_life_gen_scheduler;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int CELLS = W * H;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       step;
    logic       frame_start;
    logic       eng_valid;
    logic       eng_ready = 1'b0;
    logic [5:0] eng_x;
    logic [4:0] eng_y;
    logic       res_valid = 1'b0;
    logic       res_data  = 1'b0;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [4:0] wr_y;
    logic       wr_data;
    logic       disp_bank;
    logic       busy;
    logic [15:0] gen_count;

    int n_checks = 0;
    int n_errors = 0;

    int   issue_total = 0;
    int   wr_total    = 0;
    int   last_ix     = 0;
    int   last_iy     = 0;
    logic ready_mode  = 1'b0;
    logic inject      = 1'b0;

    life_gen_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .step        (step),
        .frame_start (frame_start),
        .eng_valid   (eng_valid),
        .eng_ready   (eng_ready),
        .eng_x       (eng_x),
        .eng_y       (eng_y),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .disp_bank   (disp_bank),
        .busy        (busy),
        .gen_count   (gen_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic cell_model(input int x, input int y);
        return ((x + 2 * y) % 3) == 0;
    endfunction

    // Engine model: ready pattern, issue-order checks, delayed echo, write-order checks.
    logic [2:0] pipe_v = '0;
    logic [2:0] pipe_d = '0;
    logic       prev_stall = 1'b0;
    int         prev_x = 0;
    int         prev_y = 0;
    int         ph = 0;

    always @(negedge clk) begin
        logic fire;
        int   idx;
        if (!reset_n) begin
            pipe_v      = '0;
            pipe_d      = '0;
            res_valid   = 1'b0;
            res_data    = 1'b0;
            eng_ready   = 1'b0;
            issue_total = 0;
            wr_total    = 0;
            prev_stall  = 1'b0;
            ph          = 0;
        end else begin
            if (prev_stall && eng_valid) begin
                check("stall_x", 32'(eng_x), 32'(prev_x));
                check("stall_y", 32'(eng_y), 32'(prev_y));
            end
            eng_ready = ready_mode ? ((ph == 0) || (ph == 3)) : 1'b1;
            ph        = (ph + 1) % 4;
            fire      = eng_valid && eng_ready;
            if (fire) begin
                idx = issue_total % CELLS;
                check("issue_x", 32'(eng_x), 32'(idx % W));
                check("issue_y", 32'(eng_y), 32'(idx / W));
                last_ix = int'(eng_x);
                last_iy = int'(eng_y);
                issue_total++;
            end
            res_valid  = pipe_v[2] | inject;
            res_data   = pipe_v[2] ? pipe_d[2] : 1'b1;
            pipe_v     = {pipe_v[1:0], fire};
            pipe_d     = {pipe_d[1:0], cell_model(int'(eng_x), int'(eng_y))};
            prev_stall = eng_valid && !eng_ready;
            prev_x     = int'(eng_x);
            prev_y     = int'(eng_y);
            #1;
            if (wr_en) begin
                idx = wr_total % CELLS;
                check("wr_x", 32'(wr_x), 32'(idx % W));
                check("wr_y", 32'(wr_y), 32'(idx / W));
                check("wr_data", 32'(wr_data), 32'(cell_model(idx % W, idx / W)));
                wr_total++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_issue(input int target, input int budget);
        int n = 0;
        while (issue_total < target && n < budget) begin
            tick();
            n++;
        end
        check("issue_timeout", 32'(issue_total), 32'(target));
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_total < target && n < budget) begin
            tick();
            n++;
        end
        check("wr_timeout", 32'(wr_total), 32'(target));
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    initial begin
        int n;
        reset_n     = 1'b0;
        enable      = 1'b0;
        step        = 1'b0;
        frame_start = 1'b0;
        repeat (3) tick();
        check("rst_eng_valid", 32'(eng_valid), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_disp_bank", 32'(disp_bank), 0);
        check("rst_gen_count", 32'(gen_count), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        // Reset in the middle of a sweep at cell (12,7).
        pulse_step();
        n = 0;
        while (!(eng_x == 6'd12 && eng_y == 5'd7) && n < 1000) begin
            tick();
            n++;
        end
        check("reach_12_7", 32'(eng_x) + 32'(eng_y) * 100, 12 + 7 * 100);
        reset_n = 1'b0;
        tick();
        tick();
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_eng_valid", 32'(eng_valid), 0);
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_disp_bank", 32'(disp_bank), 0);
        check("mid_rst_gen_count", 32'(gen_count), 0);
        check("mid_rst_eng_xy", 32'(eng_x) + 32'(eng_y), 0);
        reset_n = 1'b1;
        tick();

        // Full generation with ready stuck high.
        pulse_step();
        check("gen1_busy", 32'(busy), 1);
        check("gen1_first_valid", 32'(eng_valid), 1);
        check("gen1_first_x", 32'(eng_x), 0);
        check("gen1_first_y", 32'(eng_y), 0);
        wait_wr(CELLS, 2000);
        tick();
        check("gen1_issue_count", 32'(issue_total), CELLS);
        check("gen1_last_ix", 32'(last_ix), W - 1);
        check("gen1_last_iy", 32'(last_iy), H - 1);
        repeat (5) tick();
        check("gen1_busy_hold", 32'(busy), 1);
        check("gen1_no_early_swap", 32'(disp_bank), 0);
        pulse_frame();
        check("gen1_disp_bank", 32'(disp_bank), 1);
        check("gen1_gen_count", 32'(gen_count), 1);
        check("gen1_idle", 32'(busy), 0);

        // Frame pulses during SWEEP and DRAIN must not swap.
        pulse_step();
        repeat (50) tick();
        pulse_frame();
        check("sweep_no_swap", 32'(disp_bank), 1);
        wait_issue(2 * CELLS, 2000);
        tick();
        pulse_frame();
        check("drain_no_swap", 32'(disp_bank), 1);
        check("drain_gen_count", 32'(gen_count), 1);
        wait_wr(2 * CELLS, 100);
        tick();
        check("pend_busy", 32'(busy), 1);
        pulse_step();
        repeat (3) tick();
        check("pend_step_ignored", 32'(issue_total), 2 * CELLS);
        check("pend_step_busy", 32'(busy), 1);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick();
        check("pend_res_ignored", 32'(wr_total), 2 * CELLS);
        step        = 1'b1;
        frame_start = 1'b1;
        tick();
        step        = 1'b0;
        frame_start = 1'b0;
        check("gen2_disp_bank", 32'(disp_bank), 0);
        check("gen2_gen_count", 32'(gen_count), 2);
        check("step_at_return", 32'(busy), 0);
        tick();
        check("step_at_return_hold", 32'(busy), 0);

        enable = 1'b0;
        pulse_step();
        tick();
        check("step_disabled", 32'(busy), 0);
        enable = 1'b1;
        tick();

        // Backpressure plus an enable drop after 100 issues.
        ready_mode = 1'b1;
        pulse_step();
        wait_issue(2 * CELLS + 100, 1000);
        enable = 1'b0;
        repeat (20) tick();
        check("en_drop_issue_hold", 32'(issue_total), 2 * CELLS + 100);
        check("en_drop_valid", 32'(eng_valid), 0);
        check("en_drop_writes", 32'(wr_total), 2 * CELLS + 100);
        check("en_drop_busy", 32'(busy), 1);
        enable = 1'b1;
        wait_issue(2 * CELLS + 101, 100);
        check("resume_x", 32'(last_ix), 20);
        check("resume_y", 32'(last_iy), 2);
        wait_wr(3 * CELLS, 5000);
        repeat (2) tick();
        pulse_frame();
        check("gen3_disp_bank", 32'(disp_bank), 1);
        check("gen3_gen_count", 32'(gen_count), 3);
        ready_mode = 1'b0;
        tick();

        // Idle frame pulses: auto-start only when the feature is built in.
        for (int i = 0; i < 7; i++) begin
            pulse_frame();
            tick();
        end
        check("auto_before_8th", 32'(busy), 0);
        pulse_frame();
`ifdef LIFE_SCHED_AUTO_STEP_EN
        check("auto_start_busy", 32'(busy), 1);
        check("auto_start_valid", 32'(eng_valid), 1);
`else
        check("no_auto_start", 32'(busy), 0);
`endif
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
